// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: register-index width, hazard FSM states, operand match helper.
package cpu_pkg;
  localparam int REG_IDX_W   = 5;
  localparam int ADDR_W      = 32;
  localparam int STALL_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    IMEM_WAIT  = 2'd2
  } hz_state_e;

  // True when an ID source operand is actually read and names the EX destination.
  function automatic logic src_match(input logic [REG_IDX_W-1:0] rd,
                                     input logic [REG_IDX_W-1:0] rs,
                                     input logic                 used);
    return used && (rd == rs);
  endfunction
endpackage

// File: rtl/perf_cnt.sv
// Saturating event counter; increments one cycle after i_inc, sticks at all-ones.
module perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch redirect, imem wait; outputs are combinational.
// HAZARD_CTRL_PERF_EN adds saturating stall_cnt/flush_cnt perf outputs.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_ex_mem_read,
  input  logic [REG_IDX_W-1:0] id_ex_rd,
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  input  logic                 if_id_rs1_used,
  input  logic                 if_id_rs2_used,
  input  logic                 br_taken,
  input  logic [ADDR_W-1:0]    br_target,
  input  logic                 imem_ready,
  output logic                 stall_pc,
  output logic                 br_sel,
  output logic [ADDR_W-1:0]    redirect_addr,
  output logic                 stall_if_id,
  output logic                 flush_if_id,
  output logic                 flush_id_ex
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
`endif
);
  localparam logic [STALL_CNT_W-1:0] LS_LOAD = STALL_CNT_W'(LOAD_STALL_CYC - 1);

  if (LOAD_STALL_CYC < 1 || LOAD_STALL_CYC > 15 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: illegal LOAD_STALL_CYC or CNT_W");
  end

  hz_state_e               r_state, w_state_nxt;
  logic                    r_pend_vld, w_pend_vld_nxt;
  logic [ADDR_W-1:0]       r_pend_addr, w_pend_addr_nxt;
  logic [STALL_CNT_W-1:0]  r_scnt, w_scnt_nxt;
  logic                    w_load_use;

  assign w_load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      (src_match(id_ex_rd, if_id_rs1, if_id_rs1_used) ||
                       src_match(id_ex_rd, if_id_rs2, if_id_rs2_used));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_scnt      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_scnt      <= w_scnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_addr_nxt = r_pend_addr;
    w_scnt_nxt      = r_scnt;
    case (r_state)
      RUN: begin
        // The ID instruction is wrong-path when a branch resolves, so the branch wins.
        if (br_taken) begin
          if (!imem_ready) begin
            w_state_nxt     = IMEM_WAIT;
            w_pend_vld_nxt  = 1'b1;
            w_pend_addr_nxt = br_target;
          end
        end else if (w_load_use) begin
          w_scnt_nxt = LS_LOAD;
          if (LOAD_STALL_CYC > 1) w_state_nxt = LOAD_STALL;
        end else if (!imem_ready) begin
          w_state_nxt = IMEM_WAIT;
        end
      end
      LOAD_STALL: begin
        // The RUN cycle that detected the hazard is the first stall cycle.
        w_scnt_nxt = r_scnt - 1'b1;
        if (r_scnt <= STALL_CNT_W'(1)) w_state_nxt = RUN;
      end
      IMEM_WAIT: begin
        if (imem_ready) begin
          w_state_nxt    = RUN;
          w_pend_vld_nxt = 1'b0;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    stall_pc      = 1'b0;
    br_sel        = 1'b0;
    redirect_addr = br_target;
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    if (!rst_n) begin
      stall_pc      = 1'b1;
      redirect_addr = '0;
    end else begin
      case (r_state)
        RUN: begin
          if (br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (imem_ready) br_sel   = 1'b1;
            else            stall_pc = 1'b1;
          end else if (w_load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (!imem_ready) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
          end
        end
        LOAD_STALL: begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        IMEM_WAIT: begin
          if (!imem_ready) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
          end else if (r_pend_vld) begin
            br_sel        = 1'b1;
            redirect_addr = r_pend_addr;
          end
        end
        default: stall_pc = 1'b1;
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) (r_state != RUN) |-> !br_taken)
    else $error("hazard_ctrl: br_taken outside RUN is ignored");

`ifdef HAZARD_CTRL_PERF_EN
  logic w_br_flush;
  assign w_br_flush = rst_n && (r_state == RUN) && br_taken;

  perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (stall_pc),
    .o_cnt (stall_cnt)
  );

  perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_br_flush),
    .o_cnt (flush_cnt)
  );
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LOAD_STALL_CYC, default 1, giving the load-use stall length in cycles (legal range 1..15).
REQ-002 SHALL have parameter CNT_W, default 32, giving the perf counter width.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge; one clock.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: id_ex_mem_read  in  1  the instruction in EX is a load.
REQ-006 SHALL have ports: id_ex_rd  in  5  destination register of the instruction in EX.
REQ-007 SHALL have ports: if_id_rs1/if_id_rs2  in  5 each  source registers of the instruction in ID.
REQ-008 SHALL have ports: if_id_rs1_used/if_id_rs2_used  in  1 each  source operand is actually read.
REQ-009 SHALL have ports: br_taken  in  1  branch or jump resolved taken in EX.
REQ-010 SHALL have ports: br_target  in  32  resolved target address.
REQ-011 SHALL have ports: imem_ready  in  1  instruction memory returns valid data this cycle.
REQ-012 SHALL have ports: stall_pc  out  1  hold the PC.
REQ-013 SHALL have ports: br_sel  out  1  the PC loads redirect_addr.
REQ-014 SHALL have ports: redirect_addr  out  32  the next-PC value when br_sel=1.
REQ-015 SHALL have ports: stall_if_id, flush_if_id, flush_id_ex  out  1 each  pipeline register controls.

Function
REQ-016 SHALL use FSM states RUN, LOAD_STALL, IMEM_WAIT. All outputs are combinational from state, the pending register and the inputs.
REQ-017 Load-use hazard SHALL be: id_ex_mem_read && id_ex_rd!=0 && ((rs1 match && rs1_used) || (rs2 match && rs2_used)).
REQ-018 RUN with br_taken=1 and imem_ready=1 SHALL drive br_sel=1, redirect_addr=br_target, flush_if_id=1 and flush_id_ex=1 in the same cycle, then stay in RUN.
REQ-019 RUN with br_taken=1 and imem_ready=0 SHALL drive flush_id_ex=1, flush_if_id=1, stall_pc=1 and br_sel=0, latch br_target into the pending register with pend_valid=1, and go to IMEM_WAIT.
REQ-020 Branch SHALL take priority over a load-use hazard, because the ID instruction is on the wrong path and is flushed.
REQ-021 RUN with a hazard and no branch SHALL drive stall_pc=1, stall_if_id=1 and flush_id_ex=1, load stall counter = LOAD_STALL_CYC-1, and go to LOAD_STALL, or stay in RUN if LOAD_STALL_CYC=1.
REQ-022 LOAD_STALL SHALL hold stall_pc=1, stall_if_id=1 and flush_id_ex=1, decrement the counter, and return to RUN on the cycle the counter is 0. Total stall SHALL be exactly LOAD_STALL_CYC cycles.
REQ-023 RUN with imem_ready=0 and no branch or hazard SHALL drive stall_pc=1 and flush_if_id=1, and go to IMEM_WAIT.
REQ-024 IMEM_WAIT SHALL hold stall_pc=1 and flush_if_id=1 while imem_ready=0.
REQ-025 On imem_ready=1 in IMEM_WAIT: with pend_valid, the block SHALL drive br_sel=1, redirect_addr=pending, stall_pc=0, and clear pend_valid. Without pend_valid, it SHALL drive stall_pc=0. Both cases go to RUN.
REQ-026 br_taken in LOAD_STALL or IMEM_WAIT SHALL be ignored; an assertion flags it.
REQ-027 When br_sel=0, redirect_addr SHALL equal br_target.
REQ-028 imem_ready=0 during LOAD_STALL SHALL NOT extend the stall; the IMEM_WAIT check applies on return to RUN.

Reset
REQ-029 While rst_n=0, the block SHALL force state=RUN, pend_valid=0, the pending register and stall counter to 0, and perf counters to 0.
REQ-030 While rst_n=0, outputs SHALL be stall_pc=1, with br_sel, stall_if_id, flush_if_id and flush_id_ex all 0, and redirect_addr=0.
REQ-031 Reset asserted mid-stall or mid-wait SHALL discard any pending redirect immediately.

Configuration
REQ-032 With HAZARD_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt and flush_cnt, each CNT_W bits and saturating.
REQ-033 stall_cnt SHALL count cycles with stall_pc=1.
REQ-034 flush_cnt SHALL count cycles with flush_id_ex=1 caused by a branch.
REQ-035 Without HAZARD_CTRL_PERF_EN, the ports and logic SHALL be absent, with identical remaining behaviour.

Structure
REQ-036 The FSM state enum and the register-index width constant (5) SHALL live in the shared cpu_pkg.
REQ-037 The saturating counter SHALL be sub-module perf_cnt, instantiated twice only under HAZARD_CTRL_PERF_EN.

Verification
REQ-038 Hazard scenario: id_ex_mem_read=1, rd=5, rs1=5, rs1_used=1, LOAD_STALL_CYC=1 -> one cycle of stall_pc=1, stall_if_id=1, flush_id_ex=1, then RUN.
REQ-039 Long stall: same stimulus with LOAD_STALL_CYC=3 -> exactly 3 stall cycles. With rd=0 -> no stall.
REQ-040 Branch priority: br_taken=1, br_target=0x0000_0100 with a simultaneous hazard -> br_sel=1, redirect_addr=0x100, both flushes set, no stall.
REQ-041 Pending redirect: br_taken=1, target 0x0000_0200, imem_ready=0 for 4 cycles -> stall_pc=1 for 4 cycles, then br_sel=1 with redirect_addr=0x200 in one cycle.
REQ-042 Reset mid-operation: rst_n low during IMEM_WAIT with pending 0x300 -> after release, no br_sel pulse and state RUN.
REQ-043 Perf build: with HAZARD_CTRL_PERF_EN and CNT_W=4, 20 stall cycles -> stall_cnt=15, saturated.
